mem_arbiter: RTL and testbench

Parametrised shared-memory block for the RISC-V system top: N requester channels (instruction fetch, data load/store, later DMA/debug) share one single-port word-addressed RAM through a round-robin arbiter. Supports byte-enabled writes and a configurable pipelined read latency. This replaces the separate fixed-width instruction and data memories with one unified memory.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory arbiter: byte-lane width,
// read-pipeline tag layout and a one-hot to index encoder for up to 8 channels.
package mem_arb_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int BE_W        = DATA_W_DFLT / 8;
  localparam int MAX_CH      = 8;
  localparam int CH_W        = 3;

  // Control half of a read-pipeline entry; the data word is appended by the top
  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } rd_tag_t;

  function automatic logic [CH_W-1:0] onehot_idx(input logic [MAX_CH-1:0] oh);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the priority
// pointer; the pointer moves past the winner only when a transfer is strobed.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         xfer,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] cand;
  logic [PW-1:0] win_idx;
  logic          found;

  always_comb begin
    gnt     = '0;
    cand    = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_idx      = cand;
        gnt[cand]    = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (xfer && found) begin
      ptr_d = (int'(win_idx) + 1 == N) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Unified single-port word RAM shared by N_CH requesters through a round-robin
// arbiter, with byte-enabled writes and an RD_LAT-deep read-return pipeline.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_CH-1:0]              req,
  input  logic [N_CH-1:0]              we,
  input  logic [N_CH*(DATA_W/8)-1:0]   be,
  input  logic [N_CH*ADDR_W-1:0]       addr,
  input  logic [N_CH*DATA_W-1:0]       wdata,
  output logic [N_CH-1:0]              gnt,
  output logic [N_CH-1:0]              rvalid,
  output logic [DATA_W-1:0]            rdata,
  output logic                         oob
);

  localparam int              NB      = DATA_W / 8;
  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    rd_tag_t           tag;
    logic [DATA_W-1:0] data;
  } rd_entry_t;

  logic              xfer;
  logic              sel_we;
  logic [NB-1:0]     sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CH_W-1:0]   sel_ch;
  logic              in_range;
  logic [MEM_AW-1:0] mem_idx;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  rd_entry_t pipe_d [RD_LAT];
  rd_entry_t pipe_q [RD_LAT];
  rd_entry_t head;
  rd_entry_t tail;
  logic      oob_d, oob_q;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk  (CLK),
    .rst  (RST),
    .req  (req),
    .xfer (xfer),
    .gnt  (gnt)
  );

  // gnt is only ever set for a requesting channel, so any grant is a transfer
  assign xfer = |gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_we    = we[i];
        sel_be    = be[i*NB +: NB];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
    sel_ch = onehot_idx(MAX_CH'(gnt));
  end

  assign in_range = {1'b0, sel_addr} < DEPTH_L;
  assign mem_idx  = sel_addr[MEM_AW-1:0];
  assign rd_word  = in_range ? mem[mem_idx] : '0;

  always_ff @(posedge CLK) begin
    if (xfer && sel_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_be[b]) mem[mem_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // stage 0 captures the word on the transfer edge; later stages only shift
  always_comb begin
    head           = '0;
    head.tag.valid = xfer & ~sel_we;
    head.tag.ch    = sel_ch;
    head.data      = rd_word;
    pipe_d[0]      = head;
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
    oob_d = xfer & ~in_range;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < RD_LAT; s++) pipe_q[s] <= '0;
      oob_q <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      oob_q  <= oob_d;
    end
  end

  assign tail = pipe_q[RD_LAT-1];

  always_comb begin
    rvalid = '0;
    for (int i = 0; i < N_CH; i++) begin
      rvalid[i] = tail.tag.valid && (tail.tag.ch == CH_W'(i));
    end
  end

  assign rdata = tail.tag.valid ? tail.data : '0;
  assign oob   = oob_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with 3 channels, 512 words and a 3-cycle
// read latency; expected values are hand-computed constants.
module tb_mem_arbiter;

  localparam int N_CH   = 3;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;
  localparam int RD_LAT = 3;
  localparam int NB     = DATA_W / 8;

  logic                     CLK;
  logic                     RST;
  logic [N_CH-1:0]          req;
  logic [N_CH-1:0]          we;
  logic [N_CH*NB-1:0]       be;
  logic [N_CH*ADDR_W-1:0]   addr;
  logic [N_CH*DATA_W-1:0]   wdata;
  logic [N_CH-1:0]          gnt;
  logic [N_CH-1:0]          rvalid;
  logic [DATA_W-1:0]        rdata;
  logic                     oob;

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .oob(oob)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, got, want);
  endtask

  task automatic set_ch(input int c, input logic w, input logic [NB-1:0] b,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[c]                 = 1'b1;
    we[c]                  = w;
    be[c*NB +: NB]         = b;
    addr[c*ADDR_W +: ADDR_W] = a;
    wdata[c*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    RST = 1'b1; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    tick(); tick();
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    chk("rst_oob",    64'(oob),    64'h0);
    chk("rst_rdata",  64'(rdata),  64'h0);
    chk("idle_gnt",   64'(gnt),    64'h0);
    RST = 1'b0;

    // preload addr 5, then single read
    set_ch(0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    #1 chk("wr5_gnt", 64'(gnt), 64'b001);
    tick(); req = '0;
    set_ch(0, 1'b0, 4'h0, 10'd5, 32'h0);
    #1 chk("rd5_gnt", 64'(gnt), 64'b001);
    tick(); req = '0;
    chk("rd5_lat0", 64'(rvalid), 64'h0);
    chk("rd5_oob",  64'(oob),    64'h0);
    tick();
    chk("rd5_lat1", 64'(rvalid), 64'h0);
    tick();
    chk("rd5_rvalid", 64'(rvalid), 64'b001);
    chk("rd5_rdata",  64'(rdata),  64'hDEADBEEF);
    tick();
    chk("rd5_done", 64'(rvalid), 64'h0);

    // byte-enable write on ch1
    set_ch(1, 1'b1, 4'hF, 10'd3, 32'h11223344);
    #1 chk("be_gnt", 64'(gnt), 64'b010);
    tick();
    set_ch(1, 1'b1, 4'b0101, 10'd3, 32'hAABBCCDD);
    tick();
    set_ch(1, 1'b0, 4'h0, 10'd3, 32'h0);
    tick(); req = '0;
    tick(); tick();
    chk("be_rvalid", 64'(rvalid), 64'b010);
    chk("be_rdata",  64'(rdata),  64'h11BB33DD);

    // full contention, ptr starts at 2 (last grant was ch1); be=0 writes are no-ops
    set_ch(0, 1'b1, 4'h0, 10'd100, 32'h0);
    set_ch(1, 1'b1, 4'h0, 10'd101, 32'h0);
    set_ch(2, 1'b1, 4'h0, 10'd102, 32'h0);
    #1;
    for (int k = 0; k < 9; k++) begin
      chk("rr_gnt", 64'(gnt), 64'(3'b001 << ((2 + k) % 3)));
      tick();
    end
    req = 3'b011;
    #1 chk("rr_wrap", 64'(gnt), 64'b001);
    req = 3'b010;
    #1 chk("rr_single", 64'(gnt), 64'b010);
    req = 3'b000;
    #1 chk("rr_none", 64'(gnt), 64'b000);

    // back-to-back pipelined reads on ch0
    set_ch(0, 1'b1, 4'hF, 10'd0, 32'hCAFE0000); tick();
    set_ch(0, 1'b1, 4'hF, 10'd1, 32'hCAFE0001); tick();
    set_ch(0, 1'b1, 4'hF, 10'd2, 32'hCAFE0002); tick();
    set_ch(0, 1'b0, 4'h0, 10'd0, 32'h0); tick();
    chk("pipe_r0_lat", 64'(rvalid), 64'h0);
    set_ch(0, 1'b0, 4'h0, 10'd1, 32'h0); tick();
    chk("pipe_r1_lat", 64'(rvalid), 64'h0);
    set_ch(0, 1'b0, 4'h0, 10'd2, 32'h0); tick(); req = '0;
    chk("pipe_v0", 64'(rvalid), 64'b001);
    chk("pipe_d0", 64'(rdata),  64'hCAFE0000);
    tick();
    chk("pipe_v1", 64'(rvalid), 64'b001);
    chk("pipe_d1", 64'(rdata),  64'hCAFE0001);
    tick();
    chk("pipe_v2", 64'(rvalid), 64'b001);
    chk("pipe_d2", 64'(rdata),  64'hCAFE0002);
    tick();
    chk("pipe_end", 64'(rvalid), 64'h0);

    // write then read same address on the next cycle
    set_ch(1, 1'b1, 4'hF, 10'd7, 32'h5); tick(); req = '0;
    set_ch(0, 1'b0, 4'h0, 10'd7, 32'h0);
    #1 chk("wtr_gnt", 64'(gnt), 64'b001);
    tick(); req = '0;
    tick(); tick();
    chk("wtr_rvalid", 64'(rvalid), 64'b001);
    chk("wtr_rdata",  64'(rdata),  64'h5);

    // out-of-range read returns 0 with normal timing
    set_ch(2, 1'b0, 4'h0, 10'd1023, 32'h0); tick(); req = '0;
    chk("oob_rd_pulse", 64'(oob), 64'h1);
    tick();
    chk("oob_rd_clear", 64'(oob), 64'h0);
    tick();
    chk("oob_rd_rvalid", 64'(rvalid), 64'b100);
    chk("oob_rd_rdata",  64'(rdata),  64'h0);

    // last in-range word
    set_ch(0, 1'b1, 4'hF, 10'd511, 32'h12345678); tick(); req = '0;
    chk("edge511_oob", 64'(oob), 64'h0);
    set_ch(0, 1'b0, 4'h0, 10'd511, 32'h0); tick(); req = '0;
    tick(); tick();
    chk("edge511_rdata", 64'(rdata), 64'h12345678);

    // out-of-range write aliasing word 5 must be discarded
    set_ch(0, 1'b1, 4'hF, 10'd517, 32'hBAD0BAD0); tick(); req = '0;
    chk("oob_wr_pulse", 64'(oob), 64'h1);
    set_ch(0, 1'b0, 4'h0, 10'd5, 32'h0); tick(); req = '0;
    chk("oob_wr_clear", 64'(oob), 64'h0);
    tick(); tick();
    chk("oob_wr_rvalid", 64'(rvalid), 64'b001);
    chk("oob_wr_rdata",  64'(rdata),  64'hDEADBEEF);

    // reset with two reads in flight
    set_ch(0, 1'b0, 4'h0, 10'd5, 32'h0); tick();
    set_ch(0, 1'b0, 4'h0, 10'd3, 32'h0); tick(); req = '0;
    chk("flight_pre", 64'(rvalid), 64'h0);
    RST = 1'b1;
    #1 chk("flight_rst", 64'(rvalid), 64'h0);
    tick();
    chk("flight_rst_t1", 64'(rvalid), 64'h0);
    tick();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flight_post", 64'(rvalid), 64'h0);
      tick();
    end

    // channel 0 has priority right after reset
    set_ch(0, 1'b1, 4'h0, 10'd200, 32'h0);
    set_ch(1, 1'b1, 4'h0, 10'd201, 32'h0);
    #1 chk("post_rst_prio", 64'(gnt), 64'b001);
    tick();
    chk("post_rst_next", 64'(gnt), 64'b010);
    tick(); req = '0;
    #1 chk("post_rst_idle", 64'(gnt), 64'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
